text_line_sequencer: RTL and testbench
======================================

// Module: text_line_sequencer
// PURPOSE
// Drives the glyph renderer's char-select inputs. It turns the scan pixel (x,y) into the current character code and cell origin.
// Message is "GAME OVER" or "GO" from a ROM; characters appear one at a time (typewriter) on frame ticks, then hold or blink.
// Sits between VGA timing and the glyph renderer; glyph cell 10x20 px, codes 0..8 = G A M H I O V R E.
// PARAMETERS
// TEXT_X        320  left edge of cell 0 (pixels)
// TEXT_Y        230  top edge of text line (pixels)
// CHAR_PITCH    12   horizontal cell pitch (10 glyph + 2 gap)
// REVEAL_FRAMES 8    frame ticks between successive character reveals (>=1)
// BLINK_FRAMES  30   frame ticks per blink half-period in HOLD (0 = no blink)
// PORTS
// clk          in   1   system clock
// reset        in   1   synchronous, active-high reset
// x            in   10  current scan column
// y            in   10  current scan row
// frame_tick   in   1   one-cycle pulse per frame (vsync edge)
// start        in   1   one-cycle pulse: begin reveal of msg_sel
// clear        in   1   one-cycle pulse: blank text, return to IDLE
// msg_sel      in   1   0 = "GAME OVER" (9 cells), 1 = "GO" (2 cells); sampled on start only
// posx         out  32  cell origin x for glyph renderer
// posy         out  32  cell origin y (= TEXT_Y while char_en)
// select_char  out  5   glyph code; 31 = blank/space
// char_en      out  1   pixel lies in a revealed, visible, non-space cell
// busy         out  1   high in REVEAL
// done         out  1   one-cycle pulse when last char revealed
// BEHAVIOUR
// - Synchronous active-high reset: state=IDLE, count=0, tick_cnt=0, blink_on=1, msg latch=0, posx=posy=0, select_char=31, char_en=busy=done=0.
// - ROM: msg0 = G A M E _ O V E R -> 0,1,2,8,31,5,6,8,7; msg1 = G O -> 0,5. LEN = 9 / 2.
// - FSM states IDLE, REVEAL, HOLD:
//   IDLE: nothing visible. On start: latch msg_sel, count=1, tick_cnt=0, go to REVEAL; char 0 is visible in the very next cycle.
//   REVEAL: each frame_tick increments tick_cnt. When tick_cnt reaches REVEAL_FRAMES-1 with frame_tick high, tick_cnt=0 and count++.
//   REVEAL: when count becomes LEN, pulse done for exactly 1 cycle and go to HOLD (tick_cnt=0, blink_on=1).
//   HOLD: all LEN cells visible while blink_on=1. If BLINK_FRAMES>0, blink_on toggles every BLINK_FRAMES frame ticks.
//   clear in any state -> IDLE next cycle, count=0, outputs blanked. clear has priority over start in the same cycle.
//   start in REVEAL or HOLD restarts the reveal: relatch msg_sel, count=1, blink_on=1.
//   frame_tick coincident with start or clear is ignored.
// - Pixel path, 1-cycle registered latency: outputs at cycle n+1 describe x,y at cycle n.
//   Cell i spans x in [TEXT_X+i*CHAR_PITCH, TEXT_X+i*CHAR_PITCH+9] and y in [TEXT_Y, TEXT_Y+19]; gap columns belong to no cell.
//   Cell decode uses a parallel compare chain over the 9 cells; no divider.
//   Hit on cell i: posx=TEXT_X+i*CHAR_PITCH, posy=TEXT_Y, select_char=ROM[i].
//   Hit on cell i: char_en=1 iff i<count && ROM[i]!=31 && (state==REVEAL || (state==HOLD && blink_on)).
//   No hit, or i>=LEN: char_en=0, select_char=31, posx/posy hold their last value.
// - Arithmetic: x,y zero-extended to 32 bits before comparison; no wrap possible for parameter values <1024.
// TESTING
// - reset held 2 cycles -> char_en=0, select_char=31, busy=0, state IDLE; any x,y gives char_en=0.
// - start, msg_sel=0, then x=320,y=230 -> next cycle char_en=1, select_char=0, posx=320, posy=230; x=332 -> char_en=0 (count=1).
// - 8 frame ticks after start, x=335,y=249 -> char_en=1, select_char=1, posx=332.
//   x=330 (gap) -> char_en=0.
// - msg0 fully revealed (64 ticks) -> done one cycle, busy=0. x=368 (space cell 4) -> char_en=0; x=416 -> select_char=7, char_en=1.
// - HOLD with BLINK_FRAMES=30: char_en at x=320,y=230 is 1 for 30 ticks, 0 for 30, 1 again.
//   clear during HOLD -> char_en=0 next cycle, state IDLE.
// - start msg_sel=1 during REVEAL of msg0: x=332 -> select_char=5 after 8 ticks. done after 8 ticks.
//   Same-cycle start+clear -> IDLE.

Source files
------------

// File: rtl/text_line_sequencer.sv
// Typewriter text line: maps scan pixel (x,y) to glyph code and cell origin for "GAME OVER" / "GO".
// Latency: pixel outputs are registered, one cycle after the x,y they describe.
// Backpressure: none; frame_tick/start/clear are single-cycle pulses consumed as they arrive.
module text_line_sequencer #(
    parameter int TEXT_X        = 320,
    parameter int TEXT_Y        = 230,
    parameter int CHAR_PITCH    = 12,
    parameter int REVEAL_FRAMES = 8,
    parameter int BLINK_FRAMES  = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        frame_tick,
    input  logic        start,
    input  logic        clear,
    input  logic        msg_sel,
    output logic [31:0] posx,
    output logic [31:0] posy,
    output logic [4:0]  select_char,
    output logic        char_en,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, REVEAL, HOLD} state_t;

    localparam logic [31:0] REV_LAST   = 32'(REVEAL_FRAMES - 1);
    localparam logic [31:0] BLINK_LAST = (BLINK_FRAMES > 0) ? 32'(BLINK_FRAMES - 1) : 32'd0;
    localparam logic [4:0]  BLANK      = 5'd31;

    state_t      state, state_nxt;
    logic [3:0]  count, count_nxt;
    logic [31:0] tick_cnt, tick_nxt;
    logic        blink_on, blink_nxt;
    logic        msg, msg_nxt;
    logic        done_nxt;
    logic [3:0]  len;

    function automatic logic [4:0] rom_code(input logic m, input logic [3:0] i);
        logic [4:0] c;
        c = BLANK;
        if (m) begin
            case (i)
                4'd0:    c = 5'd0;
                4'd1:    c = 5'd5;
                default: c = BLANK;
            endcase
        end else begin
            case (i)
                4'd0:    c = 5'd0;
                4'd1:    c = 5'd1;
                4'd2:    c = 5'd2;
                4'd3:    c = 5'd8;
                4'd5:    c = 5'd5;
                4'd6:    c = 5'd6;
                4'd7:    c = 5'd8;
                4'd8:    c = 5'd7;
                default: c = BLANK;
            endcase
        end
        return c;
    endfunction

    assign len  = msg ? 4'd2 : 4'd9;
    assign busy = (state == REVEAL);

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        tick_nxt  = tick_cnt;
        blink_nxt = blink_on;
        msg_nxt   = msg;
        done_nxt  = 1'b0;
        if (clear) begin
            state_nxt = IDLE;
            count_nxt = 4'd0;
            tick_nxt  = 32'd0;
            blink_nxt = 1'b1;
        end else if (start) begin
            state_nxt = REVEAL;
            msg_nxt   = msg_sel;
            count_nxt = 4'd1;
            tick_nxt  = 32'd0;
            blink_nxt = 1'b1;
        end else begin
            case (state)
                REVEAL: begin
                    if (frame_tick) begin
                        if (tick_cnt == REV_LAST) begin
                            tick_nxt  = 32'd0;
                            count_nxt = count + 4'd1;
                            if (count + 4'd1 == len) begin
                                state_nxt = HOLD;
                                done_nxt  = 1'b1;
                                blink_nxt = 1'b1;
                            end
                        end else begin
                            tick_nxt = tick_cnt + 32'd1;
                        end
                    end
                end
                HOLD: begin
                    if (frame_tick && (BLINK_FRAMES > 0)) begin
                        if (tick_cnt == BLINK_LAST) begin
                            tick_nxt  = 32'd0;
                            blink_nxt = ~blink_on;
                        end else begin
                            tick_nxt = tick_cnt + 32'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Parallel compare chain: at most one cell can match since pitch >= glyph width.
    logic [31:0] x_ext, y_ext, cell_x, hit_x;
    logic        in_row, hit, pix_hit, visible, en_nxt;
    logic [3:0]  hit_idx;
    logic [4:0]  code;

    always_comb begin
        x_ext   = {22'd0, x};
        y_ext   = {22'd0, y};
        in_row  = (y_ext >= 32'(TEXT_Y)) && (y_ext <= 32'(TEXT_Y + 19));
        hit     = 1'b0;
        hit_idx = 4'd0;
        hit_x   = 32'd0;
        cell_x  = 32'd0;
        for (int i = 0; i < 9; i++) begin
            cell_x = 32'(TEXT_X + i * CHAR_PITCH);
            if (in_row && (x_ext >= cell_x) && (x_ext <= cell_x + 32'd9)) begin
                hit     = 1'b1;
                hit_idx = 4'(i);
                hit_x   = cell_x;
            end
        end
        code    = rom_code(msg, hit_idx);
        pix_hit = hit && (hit_idx < len);
        visible = (state == REVEAL) || ((state == HOLD) && blink_on);
        en_nxt  = pix_hit && (hit_idx < count) && (code != BLANK) && visible;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            count       <= 4'd0;
            tick_cnt    <= 32'd0;
            blink_on    <= 1'b1;
            msg         <= 1'b0;
            done        <= 1'b0;
            posx        <= 32'd0;
            posy        <= 32'd0;
            select_char <= BLANK;
            char_en     <= 1'b0;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            tick_cnt <= tick_nxt;
            blink_on <= blink_nxt;
            msg      <= msg_nxt;
            done     <= done_nxt;
            // clear blanks immediately rather than showing one more pixel of the old state
            if (clear) begin
                select_char <= BLANK;
                char_en     <= 1'b0;
            end else if (pix_hit) begin
                posx        <= hit_x;
                posy        <= 32'(TEXT_Y);
                select_char <= code;
                char_en     <= en_nxt;
            end else begin
                select_char <= BLANK;
                char_en     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_text_line_sequencer.sv
// Directed bench for text_line_sequencer: reveal timing, cell decode, done pulse, blink, clear and restart.
module tb_text_line_sequencer;

    logic        clk;
    logic        reset;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        frame_tick;
    logic        start;
    logic        clear;
    logic        msg_sel;
    logic [31:0] posx;
    logic [31:0] posy;
    logic [4:0]  select_char;
    logic        char_en;
    logic        busy;
    logic        done;

    int n_cmp  = 0;
    int n_fail = 0;

    text_line_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .x           (x),
        .y           (y),
        .frame_tick  (frame_tick),
        .start       (start),
        .clear       (clear),
        .msg_sel     (msg_sel),
        .posx        (posx),
        .posy        (posy),
        .select_char (select_char),
        .char_en     (char_en),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Each tick: one cycle with frame_tick high, one with it low.
    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            frame_tick = 1'b1;
            cyc();
            frame_tick = 1'b0;
            cyc();
        end
    endtask

    initial begin
        reset = 1'b1; x = 10'd320; y = 10'd230;
        frame_tick = 1'b0; start = 1'b0; clear = 1'b0; msg_sel = 1'b0;
        cyc(); cyc();
        check("rst_char_en", 32'(char_en), 32'd0);
        check("rst_select", 32'(select_char), 32'd31);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_posx", posx, 32'd0);
        check("rst_posy", posy, 32'd0);
        reset = 1'b0;
        cyc(); cyc();
        check("idle_char_en", 32'(char_en), 32'd0);

        // Reveal of "GAME OVER"
        start = 1'b1; msg_sel = 1'b0;
        cyc();
        start = 1'b0;
        cyc();
        check("c0_char_en", 32'(char_en), 32'd1);
        check("c0_select", 32'(select_char), 32'd0);
        check("c0_posx", posx, 32'd320);
        check("c0_posy", posy, 32'd230);
        check("c0_busy", 32'(busy), 32'd1);
        x = 10'd332;
        cyc();
        check("c1_hidden_en", 32'(char_en), 32'd0);

        ticks(8);
        x = 10'd335; y = 10'd249;
        cyc();
        check("c1_char_en", 32'(char_en), 32'd1);
        check("c1_select", 32'(select_char), 32'd1);
        check("c1_posx", posx, 32'd332);
        x = 10'd330;
        cyc();
        check("gap_char_en", 32'(char_en), 32'd0);
        check("gap_select", 32'(select_char), 32'd31);
        check("gap_posx_hold", posx, 32'd332);

        ticks(55);
        check("pre_done_busy", 32'(busy), 32'd1);
        check("pre_done", 32'(done), 32'd0);
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        check("done_pulse", 32'(done), 32'd1);
        check("done_busy", 32'(busy), 32'd0);
        cyc();
        check("done_drop", 32'(done), 32'd0);
        x = 10'd368; y = 10'd230;
        cyc();
        check("space_char_en", 32'(char_en), 32'd0);
        check("space_select", 32'(select_char), 32'd31);
        x = 10'd416;
        cyc();
        check("c8_select", 32'(select_char), 32'd7);
        check("c8_char_en", 32'(char_en), 32'd1);
        check("c8_posx", posx, 32'd416);

        // Blink in HOLD
        x = 10'd320; y = 10'd230;
        ticks(29);
        check("blink_on_29", 32'(char_en), 32'd1);
        ticks(1);
        check("blink_off_30", 32'(char_en), 32'd0);
        ticks(29);
        check("blink_off_59", 32'(char_en), 32'd0);
        ticks(1);
        check("blink_on_60", 32'(char_en), 32'd1);

        clear = 1'b1;
        cyc();
        clear = 1'b0;
        check("clear_char_en", 32'(char_en), 32'd0);
        check("clear_busy", 32'(busy), 32'd0);
        cyc();
        check("clear_idle_en", 32'(char_en), 32'd0);

        // Restart with "GO" part-way through a "GAME OVER" reveal
        start = 1'b1; msg_sel = 1'b0;
        cyc();
        start = 1'b0;
        ticks(8);
        start = 1'b1; msg_sel = 1'b1;
        cyc();
        start = 1'b0; msg_sel = 1'b0;
        x = 10'd332;
        cyc();
        check("go_c1_hidden", 32'(char_en), 32'd0);
        check("go_c1_select", 32'(select_char), 32'd5);
        check("go_busy", 32'(busy), 32'd1);
        ticks(7);
        check("go_pre_done", 32'(done), 32'd0);
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        check("go_done", 32'(done), 32'd1);
        cyc();
        check("go_c1_char_en", 32'(char_en), 32'd1);
        check("go_c1_select2", 32'(select_char), 32'd5);
        check("go_c1_posx", posx, 32'd332);
        x = 10'd344;
        cyc();
        check("go_beyond_len_en", 32'(char_en), 32'd0);
        check("go_beyond_len_sel", 32'(select_char), 32'd31);
        check("go_beyond_posx", posx, 32'd332);

        // clear wins over start
        x = 10'd320;
        start = 1'b1; clear = 1'b1;
        cyc();
        start = 1'b0; clear = 1'b0;
        check("sc_busy", 32'(busy), 32'd0);
        check("sc_char_en", 32'(char_en), 32'd0);
        cyc();
        check("sc_idle_en", 32'(char_en), 32'd0);
        check("sc_idle_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
